// File: rtl/fifo_pkg.sv
// Shared constants and pointer-wrap helper for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 8;

  // Wrapping increment that does not assume a power-of-two depth.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping read/write pointer register with synchronous clear.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= PTR_W'(ptr_next(32'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count and flush.
// Define FIFO_FWFT_EN for first-word-fall-through read data; default is registered read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter  int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter  int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter  int unsigned AE_LEVEL   = 1,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flush masks both requests so no handshake pulse is produced for that cycle.
  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign almostfull  = (32'(count) >= AF_LEVEL);
  assign almostempty = (32'(count) <= AE_LEVEL);

  fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  // Storage is intentionally not reset; flush only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (wr_acc && !rd_acc) begin
      count <= count + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_acc;
      overflow  <= wr_en && full  && !flush;
      underflow <= rd_en && empty && !flush;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = mem[rd_ptr];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised bench for sync_fifo_param: a depth-8 and a depth-6 instance share stimulus
// and are checked every cycle against queue-based reference models.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int unsigned W = FIFO_WIDTH_DEF;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] data_in;

  logic [W-1:0] dout [2];
  logic         wack [2];
  logic         ovf  [2];
  logic         unf  [2];
  logic         ful  [2];
  logic         emp  [2];
  logic         af   [2];
  logic         ae   [2];
  logic [3:0]   cnt8;
  logic [2:0]   cnt6;

  int unsigned dep   [2] = '{8, 6};
  int unsigned af_lv [2] = '{7, 4};
  int unsigned ae_lv [2] = '{1, 2};

  logic [W-1:0] mq [2][$];
  logic [W-1:0] m_dout [2];
  logic         m_ack  [2];
  logic         m_ovf  [2];
  logic         m_unf  [2];

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(dout[0]), .wr_ack(wack[0]), .overflow(ovf[0]),
    .underflow(unf[0]), .full(ful[0]), .empty(emp[0]), .almostfull(af[0]),
    .almostempty(ae[0]), .count(cnt8)
  );

  sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(6), .AF_LEVEL(4), .AE_LEVEL(2)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(dout[1]), .wr_ack(wack[1]), .overflow(ovf[1]),
    .underflow(unf[1]), .full(ful[1]), .empty(emp[1]), .almostfull(af[1]),
    .almostempty(ae[1]), .count(cnt6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_count(input int i);
    return (i == 0) ? 32'(cnt8) : 32'(cnt6);
  endfunction

  task automatic check_inst(input int i);
    int unsigned c;
    string p;
    c = mq[i].size();
    p = (i == 0) ? "d8" : "d6";
    check({p, "_count"},     dut_count(i), 32'(c));
    check({p, "_full"},      32'(ful[i]),  32'(c == dep[i]));
    check({p, "_empty"},     32'(emp[i]),  32'(c == 0));
    check({p, "_afull"},     32'(af[i]),   32'(c >= af_lv[i]));
    check({p, "_aempty"},    32'(ae[i]),   32'(c <= ae_lv[i]));
    check({p, "_wr_ack"},    32'(wack[i]), 32'(m_ack[i]));
    check({p, "_overflow"},  32'(ovf[i]),  32'(m_ovf[i]));
    check({p, "_underflow"}, 32'(unf[i]),  32'(m_unf[i]));
`ifdef FIFO_FWFT_EN
    if (c != 0) check({p, "_data_out"}, 32'(dout[i]), 32'(mq[i][0]));
`else
    check({p, "_data_out"}, 32'(dout[i]), 32'(m_dout[i]));
`endif
  endtask

  // Queue-level model of one clock edge; uses the pre-edge occupancy only.
  task automatic model_edge(input logic w, input logic r, input logic f, input logic [W-1:0] d);
    for (int i = 0; i < 2; i++) begin
      int unsigned c;
      logic is_full, is_empty;
      c        = mq[i].size();
      is_full  = (c == dep[i]);
      is_empty = (c == 0);
      if (f) begin
        mq[i].delete();
        m_ack[i] = 1'b0;
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
      end else begin
        m_ack[i] = w && !is_full;
        m_ovf[i] = w && is_full;
        m_unf[i] = r && is_empty;
        if (r && !is_empty) m_dout[i] = mq[i].pop_front();
        if (w && !is_full)  mq[i].push_back(d);
      end
    end
  endtask

  task automatic cycle(input logic w, input logic r, input logic f, input logic [W-1:0] d);
    @(negedge clk);
    wr_en   = w;
    rd_en   = r;
    flush   = f;
    data_in = d;
    @(posedge clk);
    model_edge(w, r, f, d);
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_dout[i] = '0;
      m_ack[i]  = 1'b0;
      m_ovf[i]  = 1'b0;
      m_unf[i]  = 1'b0;
    end
  endtask

  task automatic check_reset_values();
    for (int i = 0; i < 2; i++) begin
      check("rst_count", dut_count(i), 32'd0);
      check("rst_empty", 32'(emp[i]),  32'd1);
      check("rst_aempty", 32'(ae[i]),  32'd1);
      check("rst_full",  32'(ful[i]),  32'd0);
      check("rst_afull", 32'(af[i]),   32'd0);
      check("rst_pulses", {29'd0, wack[i], ovf[i], unf[i]}, 32'd0);
`ifndef FIFO_FWFT_EN
      check("rst_data_out", 32'(dout[i]), 32'd0);
`endif
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    model_reset();
    #12;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // Read from empty: underflow, count stays 0.
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("uf_after_reset", 32'(unf[0]), 32'd1);

    // Fill depth 8 with 1..8, then a rejected ninth write.
    for (int k = 1; k <= 8; k++) cycle(1'b1, 1'b0, 1'b0, W'(k));
    check("d8_full_after_8", 32'(ful[0]), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, W'(9));
    check("d8_ovf_9th", 32'(ovf[0]), 32'd1);
    check("d8_no_ack_9th", 32'(wack[0]), 32'd0);

    // Full with both requests: read only.
    cycle(1'b1, 1'b1, 1'b0, W'(16'h00AA));
    check("d8_full_both_count", dut_count(0), 32'd7);

    // Drain, then empty with both requests: write only.
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, W'(16'hABCD));
    check("empty_both_count", dut_count(0), 32'd1);
    check("empty_both_uf", 32'(unf[0]), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, '0);

    // Pointer wrap on depth 6: write 6, read 3, write 3, read all.
    cycle(1'b0, 1'b0, 1'b1, '0);
    for (int k = 1; k <= 6; k++) cycle(1'b1, 1'b0, 1'b0, W'(k));
    for (int k = 0; k < 3; k++)  cycle(1'b0, 1'b1, 1'b0, '0);
    for (int k = 7; k <= 9; k++) cycle(1'b1, 1'b0, 1'b0, W'(k));
    check("d6_full_after_wrap", 32'(ful[1]), 32'd1);
    for (int k = 0; k < 6; k++)  cycle(1'b0, 1'b1, 1'b0, '0);

    // Flush at count 5 with both requests active.
    cycle(1'b0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0, W'($urandom));
    cycle(1'b1, 1'b1, 1'b1, W'(16'h5555));
    check("flush_count", dut_count(0), 32'd0);
    check("flush_no_ack", 32'(wack[0]), 32'd0);

    // Randomised traffic in phases of differing write/read bias.
    for (int n = 0; n < 800; n++) begin
      int unsigned wp, rp;
      wp = (n < 200) ? 80 : (n < 400) ? 30 : 55;
      rp = (n < 200) ? 30 : (n < 400) ? 80 : 55;
      cycle(1'b1 && ($urandom_range(99) < wp), $urandom_range(99) < rp,
            $urandom_range(63) == 0, W'($urandom));
      if (n == 500) begin
        @(negedge clk);
        wr_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
